// File: rtl/mem_arbiter.sv
// Two-master arbiter for a single shared memory/IO port.
// Grants are round-robin; a locked owner may keep the port for up to MAX_HOLD cycles while contended.
module mem_arbiter #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_lock,
    input  logic [1:0]  m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wd,
    output logic [31:0] m0_rdata,
    output logic        m0_ack,
    input  logic        m1_req,
    input  logic        m1_lock,
    input  logic [1:0]  m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wd,
    output logic [31:0] m1_rdata,
    output logic        m1_ack,
    output logic [1:0]  s_we,
    output logic [31:0] s_addr,
    output logic [31:0] s_wd,
    input  logic [31:0] s_data,
    output logic [1:0]  owner
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD - 1);

    state_t     state;
    state_t     state_nxt;
    state_t     other_st;
    logic [7:0] hold_cnt;
    logic       last_owner;
    logic       own_req;
    logic       own_lock;
    logic       oth_req;

    assign owner = state;

    // Present the current owner's and the contender's controls uniformly to the transition logic.
    always_comb begin
        own_req  = 1'b0;
        own_lock = 1'b0;
        oth_req  = 1'b0;
        other_st = IDLE;
        case (state)
            OWN0: begin
                own_req  = m0_req;
                own_lock = m0_lock;
                oth_req  = m1_req;
                other_st = OWN1;
            end
            OWN1: begin
                own_req  = m1_req;
                own_lock = m1_lock;
                oth_req  = m0_req;
                other_st = OWN0;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (m0_req && m1_req) begin
                    state_nxt = last_owner ? OWN0 : OWN1;
                end else if (m0_req) begin
                    state_nxt = OWN0;
                end else if (m1_req) begin
                    state_nxt = OWN1;
                end
            end
            OWN0, OWN1: begin
                if (!own_req) begin
                    state_nxt = oth_req ? other_st : IDLE;
                end else if (own_lock && (hold_cnt < HOLD_LIMIT || !oth_req)) begin
                    state_nxt = state;
                end else if (oth_req) begin
                    state_nxt = other_st;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            hold_cnt   <= '0;
            last_owner <= 1'b1;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) begin
                hold_cnt <= '0;
                if (state_nxt == OWN0) begin
                    last_owner <= 1'b0;
                end else if (state_nxt == OWN1) begin
                    last_owner <= 1'b1;
                end
            end else if (own_req && hold_cnt < HOLD_LIMIT) begin
                hold_cnt <= hold_cnt + 8'd1;
            end
        end
    end

    // Shared-port write size is gated by the owner's request so a dropped request never writes.
    always_comb begin
        s_we     = '0;
        s_addr   = '0;
        s_wd     = '0;
        m0_ack   = 1'b0;
        m1_ack   = 1'b0;
        m0_rdata = '0;
        m1_rdata = '0;
        case (state)
            OWN0: begin
                s_addr   = m0_addr;
                s_wd     = m0_wd;
                s_we     = m0_req ? m0_we : 2'b00;
                m0_ack   = m0_req;
                m0_rdata = s_data;
            end
            OWN1: begin
                s_addr   = m1_addr;
                s_wd     = m1_wd;
                s_we     = m1_req ? m1_we : 2'b00;
                m1_ack   = m1_req;
                m1_rdata = s_data;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: models the shared memory and checks each ack against queued expectations.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_lock, m1_req, m1_lock;
    logic [1:0]  m0_we, m1_we, s_we, owner;
    logic [31:0] m0_addr, m0_wd, m0_rdata, m1_addr, m1_wd, m1_rdata;
    logic        m0_ack, m1_ack;
    logic [31:0] s_addr, s_wd, s_data;

    logic [31:0] mem [0:255];
    logic        init_mem;
    int unsigned wr_cnt;

    typedef struct {
        logic        m;
        logic [1:0]  we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    int unsigned total = 0;
    int unsigned passed = 0;

    mem_arbiter #(.MAX_HOLD(16)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_lock(m0_lock), .m0_we(m0_we), .m0_addr(m0_addr),
        .m0_wd(m0_wd), .m0_rdata(m0_rdata), .m0_ack(m0_ack),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_we(m1_we), .m1_addr(m1_addr),
        .m1_wd(m1_wd), .m1_rdata(m1_rdata), .m1_ack(m1_ack),
        .s_we(s_we), .s_addr(s_addr), .s_wd(s_wd), .s_data(s_data),
        .owner(owner)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input int unsigned i);
        return 32'h5A00_0000 | (32'(i) << 8) | 32'(i);
    endfunction

    assign s_data = mem[s_addr[9:2]];

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= pat(i);
            wr_cnt <= 0;
        end else if (s_we != 2'b00) begin
            wr_cnt <= wr_cnt + 1;
            case (s_we)
                2'b01:   mem[s_addr[9:2]][{s_addr[1:0], 3'b000} +: 8] <= s_wd[7:0];
                2'b10:   mem[s_addr[9:2]][{s_addr[1], 4'b0000} +: 16] <= s_wd[15:0];
                default: mem[s_addr[9:2]] <= s_wd;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic observe();
        exp_t e;
        if (m0_ack || m1_ack) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_ack", 32'({m1_ack, m0_ack}), 32'd0);
            end else begin
                e = sb.pop_front();
                check("sb_master", 32'({m1_ack, m0_ack}), e.m ? 32'd2 : 32'd1);
                check("sb_addr", s_addr, e.addr);
                check("sb_we", 32'(s_we), 32'(e.we));
                if (e.we != 2'b00) check("sb_wd", s_wd, e.wd);
                else check("sb_rdata", e.m ? m1_rdata : m0_rdata, e.rdata);
            end
        end
    endtask

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        observe();
    endtask

    task automatic clear_inputs();
        m0_req = 0; m0_lock = 0; m0_we = '0; m0_addr = '0; m0_wd = '0;
        m1_req = 0; m1_lock = 0; m1_we = '0; m1_addr = '0; m1_wd = '0;
    endtask

    // Returns just after the reset release; the next posedge is the first arbitration edge.
    task automatic apply_reset();
        drive_edge();
        reset = 1'b1;
        clear_inputs();
        drive_edge();
        reset = 1'b0;
    endtask

    initial begin
        int unsigned wc;
        reset = 1'b1;
        init_mem = 1'b1;
        clear_inputs();
        drive_edge();
        init_mem = 1'b0;
        sample();
        check("rst_owner", 32'(owner), 32'd0);
        check("rst_s_we", 32'(s_we), 32'd0);
        check("rst_s_addr", s_addr, 32'd0);
        check("rst_s_wd", s_wd, 32'd0);
        check("rst_acks", 32'({m1_ack, m0_ack}), 32'd0);
        check("rst_rdata", m0_rdata | m1_rdata, 32'd0);
        check("rst_hold_cnt", 32'(dut.hold_cnt), 32'd0);
        check("rst_last_owner", 32'(dut.last_owner), 32'd1);

        // Single word write from m0, then m1 reads it back.
        apply_reset();
        m0_req = 1; m0_we = 2'b11; m0_addr = 32'h100; m0_wd = 32'hDEADBEEF;
        sb.push_back('{1'b0, 2'b11, 32'h100, 32'hDEADBEEF, 32'h0});
        sample();
        check("t1_c0_owner", 32'(owner), 32'd0);
        check("t1_c0_ack", 32'(m0_ack), 32'd0);
        drive_edge();
        sample();
        check("t1_c1_owner", 32'(owner), 32'd1);
        check("t1_c1_ack", 32'(m0_ack), 32'd1);
        check("t1_c1_s_we", 32'(s_we), 32'd3);
        check("t1_c1_s_addr", s_addr, 32'h100);
        check("t1_c1_m1_quiet", 32'(m1_ack) | m1_rdata, 32'd0);
        drive_edge();
        m0_req = 0;
        sample();
        check("t1_c2_owner", 32'(owner), 32'd1);
        check("t1_c2_s_we", 32'(s_we), 32'd0);
        check("t1_c2_ack", 32'(m0_ack), 32'd0);
        drive_edge();
        sample();
        check("t1_c3_owner", 32'(owner), 32'd0);
        check("t1_c3_s_addr", s_addr, 32'd0);
        check("t1_mem", mem[8'h40], 32'hDEADBEEF);
        drive_edge();
        m1_req = 1; m1_we = 2'b00; m1_addr = 32'h100;
        sb.push_back('{1'b1, 2'b00, 32'h100, 32'h0, 32'hDEADBEEF});
        sample();
        drive_edge();
        sample();
        check("t1_rd_owner", 32'(owner), 32'd2);
        check("t1_rd_m0_rdata", m0_rdata, 32'd0);
        drive_edge();
        m1_req = 0;
        sample();
        drive_edge();
        sample();
        check("t1_rd_idle", 32'(owner), 32'd0);
        check("t1_last_owner", 32'(dut.last_owner), 32'd1);

        // Both masters reading continuously: strict alternation starting with m0.
        apply_reset();
        m0_req = 1; m0_we = 2'b00; m0_addr = 32'h200;
        m1_req = 1; m1_we = 2'b00; m1_addr = 32'h300;
        sample();
        check("t2_c0_owner", 32'(owner), 32'd0);
        for (int k = 0; k < 4; k++) begin
            drive_edge();
            if (k % 2 == 0) sb.push_back('{1'b0, 2'b00, 32'h200, 32'h0, pat(8'h80)});
            else sb.push_back('{1'b1, 2'b00, 32'h300, 32'h0, pat(8'hC0)});
            sample();
            check("t2_rr_owner", 32'(owner), (k % 2 == 0) ? 32'd1 : 32'd2);
        end
        drive_edge();
        m0_req = 0; m1_req = 0;
        sample();
        check("t2_drop_acks", 32'({m1_ack, m0_ack}), 32'd0);
        drive_edge();
        sample();
        check("t2_idle", 32'(owner), 32'd0);

        // Locked m0 under contention: 16 acks, then m1; m1 input churn must not leak to the port.
        apply_reset();
        m0_req = 1; m0_lock = 1; m0_we = 2'b11; m0_addr = 32'hF0; m0_wd = 32'h1234_0000;
        m1_req = 1; m1_we = 2'b00; m1_addr = 32'h300;
        sample();
        for (int i = 0; i < 16; i++) begin
            drive_edge();
            m0_wd = 32'h1234_0000 + 32'(i);
            m1_addr = $urandom;
            m1_wd = $urandom;
            sb.push_back('{1'b0, 2'b11, 32'hF0, m0_wd, 32'h0});
            sample();
            check("t3_lock_owner", 32'(owner), 32'd1);
        end
        drive_edge();
        m0_req = 0; m0_lock = 0; m1_addr = 32'h300;
        sb.push_back('{1'b1, 2'b00, 32'h300, 32'h0, pat(8'hC0)});
        sample();
        check("t3_handover_owner", 32'(owner), 32'd2);
        check("t3_handover_m0_ack", 32'(m0_ack), 32'd0);
        check("t3_mem", mem[8'h3C], 32'h1234_000F);
        drive_edge();
        m1_req = 0;
        sample();
        drive_edge();
        sample();
        check("t3_idle", 32'(owner), 32'd0);

        // Locked m0 without contention keeps the port; hold counter saturates.
        apply_reset();
        m0_req = 1; m0_lock = 1; m0_we = 2'b00; m0_addr = 32'h200;
        sample();
        for (int i = 0; i < 40; i++) begin
            drive_edge();
            sb.push_back('{1'b0, 2'b00, 32'h200, 32'h0, pat(8'h80)});
            sample();
            check("t4_hold_owner", 32'(owner), 32'd1);
        end
        check("t4_hold_cnt_sat", 32'(dut.hold_cnt), 32'd15);
        drive_edge();
        m1_req = 1; m1_we = 2'b00; m1_addr = 32'h300;
        sb.push_back('{1'b0, 2'b00, 32'h200, 32'h0, pat(8'h80)});
        sample();
        check("t4_req_cycle_owner", 32'(owner), 32'd1);
        drive_edge();
        m0_req = 0; m0_lock = 0;
        sb.push_back('{1'b1, 2'b00, 32'h300, 32'h0, pat(8'hC0)});
        sample();
        check("t4_switch_owner", 32'(owner), 32'd2);
        check("t4_hold_cnt_clr", 32'(dut.hold_cnt), 32'd0);
        drive_edge();
        m1_req = 0;
        sample();
        drive_edge();
        sample();
        check("t4_idle", 32'(owner), 32'd0);

        // m1 byte write, then request drops with we still set.
        apply_reset();
        m1_req = 1; m1_we = 2'b01; m1_addr = 32'h104; m1_wd = 32'hFFFF_FFA5;
        sb.push_back('{1'b1, 2'b01, 32'h104, 32'hFFFF_FFA5, 32'h0});
        sample();
        drive_edge();
        sample();
        check("t5_owner", 32'(owner), 32'd2);
        drive_edge();
        m1_req = 0;
        sample();
        check("t5_drop_s_we", 32'(s_we), 32'd0);
        check("t5_drop_ack", 32'(m1_ack), 32'd0);
        check("t5_drop_owner", 32'(owner), 32'd2);
        drive_edge();
        sample();
        check("t5_idle", 32'(owner), 32'd0);
        check("t5_mem_byte", mem[8'h41], 32'h5A00_41A5);

        // Asynchronous reset in the middle of a word write must suppress it.
        apply_reset();
        m0_req = 1; m0_we = 2'b11; m0_addr = 32'h180; m0_wd = 32'hCAFE_F00D;
        sample();
        drive_edge();
        check("t6_pre_ack", 32'(m0_ack), 32'd1);
        check("t6_pre_s_we", 32'(s_we), 32'd3);
        wc = wr_cnt;
        #2;
        reset = 1'b1;
        #1;
        check("t6_async_owner", 32'(owner), 32'd0);
        check("t6_async_s_we", 32'(s_we), 32'd0);
        check("t6_async_ack", 32'(m0_ack), 32'd0);
        @(posedge clk);
        #1;
        check("t6_no_write_cnt", wr_cnt, wc);
        check("t6_no_write_mem", mem[8'h60], 32'h5A00_6060);
        reset = 1'b0;
        clear_inputs();
        sample();
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
